// File: rtl/data_sram_responder.sv
// Responder end of the CPU data SRAM interface: byte-lane writes, 1- or 2-cycle read pipeline,
// out-of-range trap and saturating access counters. Optional write-first result: DATA_SRAM_RESPONDER_WFIRST_EN.
module data_sram_responder #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic        err_flag,
  output logic [31:0] err_addr,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  localparam int unsigned LP_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [63:0] LP_BYTES = 64'd4 << ADDR_WIDTH;

  logic [31:0]           w_off;
  logic                  w_in_range;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_acc;
  logic                  w_wr;
  logic                  w_rd;
  logic [31:0]           w_rd1;

  assign w_off      = sram_addr - BASE_ADDR;
  assign w_in_range = {32'd0, w_off} < LP_BYTES;
  assign w_idx      = w_off[ADDR_WIDTH+1:2];
  // A request coinciding with reset is ignored entirely.
  assign w_acc      = sram_en && !rst;
  assign w_wr       = w_acc && (sram_wen != 4'h0) && w_in_range;
  assign w_rd       = w_acc && (sram_wen == 4'h0) && w_in_range;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [LP_DEPTH];
      logic [7:0] r_rd1_byte;

      always_ff @(posedge clk) begin
        if (w_wr && sram_wen[gi]) begin
          r_mem[w_idx] <= sram_wdata[8*gi +: 8];
        end
      end

      // Stage-1 result register; out-of-range accesses yield zero.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_rd1_byte <= 8'h00;
        end else if (w_acc) begin
          if (!w_in_range) begin
            r_rd1_byte <= 8'h00;
`ifdef DATA_SRAM_RESPONDER_WFIRST_EN
          end else if (sram_wen[gi]) begin
            r_rd1_byte <= sram_wdata[8*gi +: 8];
`endif
          end else begin
            r_rd1_byte <= r_mem[w_idx];
          end
        end
      end

      assign w_rd1[8*gi +: 8] = r_rd1_byte;
    end

    if (READ_LATENCY == 1) begin : g_lat1
      assign sram_rdata = w_rd1;
    end else if (READ_LATENCY == 2) begin : g_lat2
      logic        r_vld1;
      logic [31:0] r_rd2;

      // Stage 2 advances only when stage 1 captured a fresh result.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_vld1 <= 1'b0;
          r_rd2  <= 32'h0;
        end else begin
          r_vld1 <= w_acc;
          if (r_vld1) begin
            r_rd2 <= w_rd1;
          end
        end
      end

      assign sram_rdata = r_rd2;
    end else begin : g_bad_latency
      $error("data_sram_responder: READ_LATENCY must be 1 or 2");
    end
  endgenerate

  logic        r_err_flag;
  logic [31:0] r_err_addr;
  logic [31:0] r_rd_count;
  logic [31:0] r_wr_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_flag <= 1'b0;
      r_err_addr <= 32'h0;
      r_rd_count <= 32'h0;
      r_wr_count <= 32'h0;
    end else begin
      // Only the first out-of-range address is kept.
      if (w_acc && !w_in_range && !r_err_flag) begin
        r_err_flag <= 1'b1;
        r_err_addr <= sram_addr;
      end
      if (w_rd && (r_rd_count != 32'hFFFF_FFFF)) begin
        r_rd_count <= r_rd_count + 32'd1;
      end
      if (w_wr && (r_wr_count != 32'hFFFF_FFFF)) begin
        r_wr_count <= r_wr_count + 32'd1;
      end
    end
  end

  assign err_flag = r_err_flag;
  assign err_addr = r_err_addr;
  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Synchronous single-port word memory that acts as the responder end of the CPU data SRAM interface (en / wen / addr / wdata -> rdata).
- Replaces the behavioural SRAM on the memory side of the MEM stage. The CPU samples rdata in WB, one cycle after issuing the request.
- Adds byte-lane writes, a configurable read pipeline, out-of-range detection and access counters for bring-up and debug.

Parameters:
- ADDR_WIDTH, 16: word-index bits; capacity = 2^ADDR_WIDTH words.
- BASE_ADDR, 32'h0000_0000: byte address that maps to word 0.
- READ_LATENCY, 1: cycles from a request edge to valid rdata. Legal values are 1 and 2; any other value is an elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; one clock, synchronous, active-high
- sram_en  input  1  access request this cycle
- sram_wen  input  4  byte write enables; bit i writes wdata[8i+7:8i]; 0 = read
- sram_addr  input  32  byte address; bits [1:0] ignored for indexing
- sram_wdata  input  32  write data, byte lanes pre-aligned by requester
- sram_rdata  output  32  read data
- err_flag  output  1  sticky out-of-range access indicator
- err_addr  output  32  address of first out-of-range access
- rd_count  output  32  accepted in-range reads
- wr_count  output  32  accepted in-range writes

Behaviour:
- off = sram_addr - BASE_ADDR (32-bit, wraps). The access is in range iff off < 4*2^ADDR_WIDTH. Word index = off[ADDR_WIDTH+1:2].
- Write: sram_en=1 and sram_wen!=0 and in range. Only the enabled byte lanes of the indexed word are updated at the clock edge.
- Read: sram_en=1 and sram_wen==0.
- Read data and latency:
  - READ_LATENCY=1: sram_rdata is registered and presents the word for the request sampled at edge N immediately after edge N.
  - READ_LATENCY=2: one extra output register; data appears after edge N+1.
  - Back-to-back requests are accepted every cycle with no stall.
- Every enabled cycle, including writes, produces an rdata result through the pipeline. For a write cycle the result is the read-first old word (see Optional Feature).
- sram_en=0: the pipeline stage holds its previous value and rdata does not change.
- Out-of-range access:
  - A read returns 32'h0 with normal latency.
  - A write is dropped; memory is unchanged.
  - If err_flag=0: set err_flag=1 and capture err_addr=sram_addr at that edge.
  - Later errors do not overwrite err_addr. The flag is cleared only by rst.
- Counters: rd_count increments on an in-range read, wr_count on an in-range write. Both saturate at 32'hFFFF_FFFF. An out-of-range access does not count.
- Reset (rst=1 at an edge):
  - sram_rdata, all pipeline registers, err_flag, err_addr, rd_count and wr_count go to 0.
  - A request in the same cycle as rst is ignored: no write, no count, no error capture.
  - Memory contents are not cleared.
- Reset mid-operation: a read in flight in the READ_LATENCY=2 pipeline is discarded and rdata = 0 after the reset edge.
- No combinational path from any input to any output.

Optional Feature:
- Macro: DATA_SRAM_RESPONDER_WFIRST_EN.
- Defined (write-first): on a write cycle, the rdata result is the merged word, i.e. the old word with the enabled lanes replaced by wdata.
- Undefined (default, read-first): the rdata result is the old word before the write.
- A read of the same address on the following cycle returns the new word in both modes.

Test Plan:
- Reset, then write 32'hDEADBEEF to 0x100 with wen=4'hF, then read 0x100 -> rdata=32'hDEADBEEF one cycle after the read (READ_LATENCY=1); wr_count=1, rd_count=1.
- Write 32'h11223344 to 0x200, then write wdata 32'hAA00_0000 with wen=4'b1000, then read -> 32'hAA223344; wr_count=2.
- Write 0x55 to 0x300 with wen=4'h1 after the word held 32'h00000000 -> rdata that cycle is 32'h00000000 (read-first) or 32'h00000055 (WFIRST_EN).
- ADDR_WIDTH=4, BASE=0: read 0x40, then write 0x44 -> rdata=0, memory unchanged, err_flag=1, err_addr=32'h40, counters unchanged.
- READ_LATENCY=2: reads of 0x0, 0x4, 0x8 on consecutive cycles -> their words appear on three consecutive cycles, starting two edges after the first request.
- READ_LATENCY=2: issue a read, then assert rst at the next edge -> rdata=0 afterwards, counters=0, err_flag=0; memory still holds its previously written data.
